// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver (LSB first) that pushes each good byte into the RX FIFO
// with a one-cycle write strobe and flags framing errors and overruns.
module uart_rx_fifo_writer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Rx,
  output logic [7:0] DataOut,
  output logic       WriteEnable,
  input  logic       Full,
  output logic       FramingError,
  output logic       Overrun,
  output logic       Busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             we_q;
  logic             fe_q;
  logic             ov_q;
  logic             busy_q;

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        // Half a bit in: confirm the start bit so later samples land mid-bit.
        ST_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s_q, shift_q[7:1]};
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        // Leaving at mid stop bit gives half a bit of slack for the next start edge.
        ST_STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              if (Full) begin
                ov_q <= 1'b1;
              end else begin
                data_q <= shift_q;
                we_q   <= 1'b1;
              end
            end else begin
              fe_q    <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          baud_cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          baud_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut      = data_q;
  assign WriteEnable  = we_q;
  assign FramingError = fe_q;
  assign Overrun      = ov_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Bench for uart_rx_fifo_writer: a fast instance (16 clks/bit) for frame tests
// and a default-rate instance (868 clks/bit) for the mid-frame reset test.
module tb_uart_rx_fifo_writer;

  localparam int CPB_A = 16;
  localparam int CPB_B = 868;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_rst, a_rx, a_full, a_we, a_fe, a_ov, a_busy;
  logic [7:0] a_data;
  logic       b_rst, b_rx, b_full, b_we, b_fe, b_ov, b_busy;
  logic [7:0] b_data;

  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB_A), .CNT_W(5)) dut_a (
    .Clk(clk), .Reset_n(a_rst), .Rx(a_rx), .DataOut(a_data), .WriteEnable(a_we),
    .Full(a_full), .FramingError(a_fe), .Overrun(a_ov), .Busy(a_busy)
  );

  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB_B), .CNT_W(10)) dut_b (
    .Clk(clk), .Reset_n(b_rst), .Rx(b_rx), .DataOut(b_data), .WriteEnable(b_we),
    .Full(b_full), .FramingError(b_fe), .Overrun(b_ov), .Busy(b_busy)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  int exp_fe_a = 0, seen_fe_a = 0, exp_ov_a = 0, seen_ov_a = 0;
  int exp_fe_b = 0, seen_fe_b = 0, exp_ov_b = 0, seen_ov_b = 0;
  int we_cnt_a = 0, we_cnt_b = 0;
  int we_cyc_a = 0, start_cyc_a = 0;
  logic a_busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: outcome follows from stop bit and Full only.
  task automatic model_frame(input int id, input logic [7:0] b, input logic stop_bit,
                             input logic full);
    if (stop_bit && !full) begin
      if (id == 0) exp_q_a.push_back(b); else exp_q_b.push_back(b);
    end else if (stop_bit) begin
      if (id == 0) exp_ov_a++; else exp_ov_b++;
    end else begin
      if (id == 0) exp_fe_a++; else exp_fe_b++;
    end
  endtask

  // ---------------- compare processes ----------------
  always @(negedge clk) begin
    if (!a_rst) begin
      chk("a_reset_outputs", {19'd0, a_data, a_we, a_fe, a_ov, a_busy}, 32'd0);
      last_a = 8'h00;
    end else begin
      if (a_we) begin
        we_cnt_a++;
        we_cyc_a = cyc;
        chk("a_busy_at_push", a_busy, 1'b0);
        chk("a_busy_before_push", a_busy_prev, 1'b1);
        if (exp_q_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected_push: got DataOut 0x%0h, expected no push", a_data);
        end else begin
          last_a = exp_q_a.pop_front();
          chk("a_push_data", a_data, last_a);
        end
      end else begin
        chk("a_data_hold", a_data, last_a);
      end
      chk("a_strobes_exclusive", (int'(a_we) + int'(a_fe) + int'(a_ov)) <= 1, 1);
      if (a_fe) seen_fe_a++;
      if (a_ov) seen_ov_a++;
    end
    a_busy_prev = a_busy;
  end

  always @(negedge clk) begin
    if (!b_rst) begin
      chk("b_reset_outputs", {19'd0, b_data, b_we, b_fe, b_ov, b_busy}, 32'd0);
      last_b = 8'h00;
    end else begin
      if (b_we) begin
        we_cnt_b++;
        if (exp_q_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected_push: got DataOut 0x%0h, expected no push", b_data);
        end else begin
          last_b = exp_q_b.pop_front();
          chk("b_push_data", b_data, last_b);
        end
      end else begin
        chk("b_data_hold", b_data, last_b);
      end
      chk("b_strobes_exclusive", (int'(b_we) + int'(b_fe) + int'(b_ov)) <= 1, 1);
      if (b_fe) seen_fe_b++;
      if (b_ov) seen_ov_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int id, input logic v);
    if (id == 0) a_rx = v; else b_rx = v;
  endtask

  task automatic send_frame(input int id, input logic [7:0] b, input logic stop_bit);
    int cpb;
    logic [9:0] bits;
    cpb  = (id == 0) ? CPB_A : CPB_B;
    bits = {stop_bit, b, 1'b0};
    model_frame(id, b, stop_bit, (id == 0) ? a_full : b_full);
    if (id == 0) start_cyc_a = cyc;
    for (int i = 0; i < 10; i++) begin
      drive(id, bits[i]);
      wait_clks(cpb);
    end
    drive(id, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int lat;
    logic [7:0] c3;
    a_rst = 1'b0; a_rx = 1'b1; a_full = 1'b0;
    b_rst = 1'b0; b_rx = 1'b1; b_full = 1'b0;
    wait_clks(3);
    chk("reset_a_dataout", a_data, 8'h00);
    chk("reset_a_busy", a_busy, 1'b0);
    a_rst = 1'b1;
    b_rst = 1'b1;
    wait_clks(5);

    // 1: single good frame
    send_frame(0, 8'hA5, 1'b1);
    wait_clks(2 * CPB_A);
    lat = we_cyc_a - start_cyc_a;
    chk("t1_latency_in_window", (lat >= 153 && lat <= 155), 1);
    chk("t1_push_count", we_cnt_a, 1);
    chk("t1_dataout", a_data, 8'hA5);
    chk("t1_busy_idle", a_busy, 1'b0);

    // 2: back-to-back frames with no idle gap
    send_frame(0, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    send_frame(0, 8'h3C, 1'b1);
    wait_clks(2 * CPB_A);
    chk("t2_push_count", we_cnt_a, 4);
    chk("t2_pending", exp_q_a.size(), 0);
    chk("t2_dataout", a_data, 8'h3C);

    // 3: start-bit glitch, 3 cycles low
    p = cyc;
    a_rx = 1'b0;
    wait_clks(3);
    a_rx = 1'b1;
    wait_clks(2);
    chk("t3_busy_in_start", a_busy, 1'b1);
    wait_clks(6);
    chk("t3_idle_cycle", cyc - p, 11);
    chk("t3_busy_back_idle", a_busy, 1'b0);
    wait_clks(12 * CPB_A);
    chk("t3_no_push", we_cnt_a, 4);

    // 4a: framing error
    send_frame(0, 8'h55, 1'b0);
    wait_clks(2 * CPB_A);
    chk("t4a_fe_count", seen_fe_a, exp_fe_a);
    chk("t4a_fe_literal", seen_fe_a, 1);
    chk("t4a_no_push", we_cnt_a, 4);

    // 4b: break held 40 bit times, then a valid frame
    a_rx = 1'b0;
    exp_fe_a++;
    wait_clks(40 * CPB_A);
    chk("t4b_busy_in_break", a_busy, 1'b1);
    a_rx = 1'b1;
    wait_clks(3 * CPB_A);
    chk("t4b_busy_after_break", a_busy, 1'b0);
    send_frame(0, 8'h81, 1'b1);
    wait_clks(2 * CPB_A);
    chk("t4b_fe_count", seen_fe_a, exp_fe_a);
    chk("t4b_fe_literal", seen_fe_a, 2);
    chk("t4b_dataout", a_data, 8'h81);

    // 5: overrun
    a_full = 1'b1;
    send_frame(0, 8'h42, 1'b1);
    wait_clks(2 * CPB_A);
    a_full = 1'b0;
    chk("t5_ov_count", seen_ov_a, exp_ov_a);
    chk("t5_ov_literal", seen_ov_a, 1);
    chk("t5_no_push", we_cnt_a, 5);
    chk("t5_dataout_kept", a_data, 8'h81);
    chk("a_fe_total", seen_fe_a, exp_fe_a);

    // 6: reset mid-frame at the default bit rate
    send_frame(1, 8'h18, 1'b1);
    wait_clks(2 * CPB_B);
    chk("t6_first_push", b_data, 8'h18);
    c3 = 8'hC3;
    b_rx = 1'b0;
    wait_clks(CPB_B);
    for (int i = 0; i < 4; i++) begin
      b_rx = c3[i];
      wait_clks(CPB_B);
    end
    b_rx = c3[4];
    wait_clks(CPB_B / 2);
    chk("t6_busy_mid_frame", b_busy, 1'b1);
    #3;
    b_rst = 1'b0;
    #1;
    chk("t6_async_reset_outputs", {19'd0, b_data, b_we, b_fe, b_ov, b_busy}, 32'd0);
    b_rx = 1'b1;
    wait_clks(4);
    b_rst = 1'b1;
    wait_clks(2 * CPB_B);
    chk("t6_no_push_aborted", we_cnt_b, 1);
    send_frame(1, 8'h7E, 1'b1);
    wait_clks(2 * CPB_B);
    chk("t6_push_count", we_cnt_b, 2);
    chk("t6_dataout", b_data, 8'h7E);
    chk("t6_pending", exp_q_b.size(), 0);
    chk("b_fe_total", seen_fe_b, exp_fe_b);
    chk("b_ov_total", seen_ov_b, exp_ov_b);
    chk("a_pending_final", exp_q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
